// File: rtl/serial_mem_load_if.sv
// serial_mem_load_if: AHB-Lite master port bundle for serial_mem_load
interface serial_mem_load_if;
  logic ahblm_hready;
  logic ahblm_hresp;
  logic [31:0] ahblm_haddr;
  logic ahblm_hwrite;
  logic [1:0] ahblm_htrans;
  logic [2:0] ahblm_hsize;
  logic [2:0] ahblm_hburst;
  logic [3:0] ahblm_hprot;
  logic ahblm_hmastlock;
  logic [31:0] ahblm_hwdata;
  logic [31:0] ahblm_hrdata;
  modport master(
    input ahblm_hready, ahblm_hresp, ahblm_hrdata,
    output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
    ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );
  modport slave(
    output ahblm_hready, ahblm_hresp, ahblm_hrdata,
    input ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
    ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );
endinterface

// File: rtl/serial_mem_load.sv
// serial_mem_load: 8N1 UART receiver packing bytes into words written to memory over AHB-Lite
module serial_mem_load #(
  parameter logic [31:0] ADDR_START = 32'h2008_0000,
  parameter logic [31:0] ADDR_STOP = 32'h2008_2000,
  parameter int CLK_DIV = 16
) (
  input logic clk,
  input logic rst,
  input logic serial_in,
  serial_mem_load_if.master bus,
  output logic done,
  output logic frame_err,
  output logic overrun_err,
  output logic bus_err
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [1:0] {B_IDLE, B_ADDR, B_DATA} bst_t;
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);
  logic [1:0] sync;
  logic rx;
  rx_t rx_state;
  logic [15:0] cnt;
  logic [2:0] bit_n;
  logic [7:0] sh;
  logic byte_valid;
  logic [1:0] byte_n;
  logic [31:0] word;
  logic [31:0] buf_word;
  logic pending;
  bst_t bst;
  logic retire;
  logic word_done;
  logic [31:0] next_addr;
  logic unused;
  assign rx = sync[1];
  assign retire = bst == B_DATA && bus.ahblm_hready;
  assign word_done = byte_valid && byte_n == 2'd3;
  assign next_addr = bus.ahblm_haddr + 32'd4;
  assign bus.ahblm_hsize = 3'b010;
  assign bus.ahblm_hburst = 3'b000;
  assign bus.ahblm_hprot = 4'b0011;
  assign bus.ahblm_hmastlock = 1'b0;
  assign unused = ^bus.ahblm_hrdata;
  // cnt starts at 1 on detection so the first data sample lands mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      rx_state <= R_IDLE;
      cnt <= '0;
      bit_n <= '0;
      sh <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], serial_in};
      byte_valid <= 1'b0;
      case (rx_state)
        R_IDLE: if (!rx) begin
          rx_state <= R_START;
          cnt <= 16'd1;
        end
        R_START: if (cnt == HALF) begin
          rx_state <= rx ? R_IDLE : R_DATA;
          cnt <= '0;
          bit_n <= '0;
        end else cnt <= cnt + 16'd1;
        R_DATA: if (cnt == FULL) begin
          sh <= {rx, sh[7:1]};
          cnt <= '0;
          bit_n <= bit_n + 3'd1;
          if (bit_n == 3'd7) rx_state <= R_STOP;
        end else cnt <= cnt + 16'd1;
        R_STOP: if (cnt == FULL) begin
          byte_valid <= rx;
          frame_err <= frame_err | !rx;
          rx_state <= R_IDLE;
        end else cnt <= cnt + 16'd1;
        default: rx_state <= R_IDLE;
      endcase
    end
  end
  // a retiring write frees the buffer in the same cycle a new word may claim it
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_n <= '0;
      word <= '0;
      buf_word <= '0;
      pending <= 1'b0;
      overrun_err <= 1'b0;
      bst <= B_IDLE;
      bus.ahblm_haddr <= ADDR_START;
      bus.ahblm_htrans <= 2'b00;
      bus.ahblm_hwrite <= 1'b0;
      bus.ahblm_hwdata <= '0;
      done <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (byte_valid) begin
        byte_n <= byte_n + 2'd1;
        word[{byte_n, 3'b000} +: 8] <= sh;
      end
      if (retire) pending <= 1'b0;
      if (word_done && !done) begin
        if (pending && !retire) overrun_err <= 1'b1;
        else begin
          buf_word <= {sh, word[23:0]};
          pending <= 1'b1;
        end
      end
      case (bst)
        B_IDLE: if (pending && !done) begin
          bst <= B_ADDR;
          bus.ahblm_htrans <= 2'b10;
          bus.ahblm_hwrite <= 1'b1;
        end
        B_ADDR: if (bus.ahblm_hready) begin
          bst <= B_DATA;
          bus.ahblm_htrans <= 2'b00;
          bus.ahblm_hwrite <= 1'b0;
          bus.ahblm_hwdata <= buf_word;
        end
        B_DATA: if (bus.ahblm_hready) begin
          bst <= B_IDLE;
          bus.ahblm_haddr <= next_addr;
          bus_err <= bus_err | bus.ahblm_hresp;
          done <= next_addr == ADDR_STOP;
        end
        default: bst <= B_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mem_load.sv
// tb_serial_mem_load: table-driven and directed checks of the serial-to-AHB loader
module tb_serial_mem_load;
  localparam int DIV = 8;
  localparam logic [31:0] START = 32'h2008_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic done, frame_err, overrun_err, bus_err;
  int total = 0;
  int bad = 0;
  logic [63:0] wq[$];
  logic in_data;
  logic [31:0] cap_addr;
  int busy_cnt;
  serial_mem_load_if bus();
  serial_mem_load #(.ADDR_START(START), .ADDR_STOP(START + 32'd8), .CLK_DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .bus(bus.master),
    .done(done),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      in_data <= 1'b0;
      busy_cnt <= 0;
    end else begin
      if (bus.ahblm_hready) begin
        if (in_data) wq.push_back({cap_addr, bus.ahblm_hwdata});
        in_data <= bus.ahblm_htrans == 2'b10;
        cap_addr <= bus.ahblm_haddr;
      end
      if (done && bus.ahblm_htrans != 2'b00) busy_cnt <= busy_cnt + 1;
    end
  end
  typedef struct {
    logic [63:0] bytes;
    int n;
    logic [7:0] bad_stop;
    int nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic done_e;
    logic ferr_e;
  } vec_t;
  vec_t vecs[4];
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic chk_write(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
    chk(name, (wq.size() > idx) ? wq[idx] : 64'h0, {a, d});
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ok);
    serial_in = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      cyc(DIV);
    end
    if (ok) begin
      serial_in = 1'b1;
      cyc(DIV);
    end else begin
      serial_in = 1'b0;
      cyc(DIV / 2);
      serial_in = 1'b1;
      cyc(DIV / 2);
    end
    cyc(DIV);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.ahblm_hready = 1'b1;
    bus.ahblm_hresp = 1'b0;
    serial_in = 1'b1;
    cyc(3);
    rst = 1'b0;
    wq.delete();
    cyc(1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic found;
    bus.ahblm_hrdata = 32'h0;
    vecs[0] = '{64'hDEADBEEF12345678, 8, 8'h00, 2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1] = '{64'h00000004030201AA, 5, 8'h01, 1, 32'h04030201, 32'h0, 1'b0, 1'b1};
    vecs[2] = '{64'h0000000000332211, 3, 8'h00, 0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[3] = '{64'h0000004433992211, 5, 8'h04, 1, 32'h44332211, 32'h0, 1'b0, 1'b1};
    do_reset();
    chk("rst_haddr", bus.ahblm_haddr, START);
    chk("rst_htrans", bus.ahblm_htrans, 0);
    chk("rst_hwrite", bus.ahblm_hwrite, 0);
    chk("rst_hwdata", bus.ahblm_hwdata, 0);
    chk("rst_flags", {done, frame_err, overrun_err, bus_err}, 0);
    chk("const_ctl", {bus.ahblm_hsize, bus.ahblm_hburst, bus.ahblm_hprot, bus.ahblm_hmastlock}, {3'b010, 3'b000, 4'b0011, 1'b0});
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].bytes[8*j +: 8], !vecs[i].bad_stop[j]);
      cyc(10);
      chk($sformatf("v%0d_nwrites", i), wq.size(), vecs[i].nw);
      if (vecs[i].nw > 0) chk_write($sformatf("v%0d_w0", i), 0, START, vecs[i].w0);
      if (vecs[i].nw > 1) chk_write($sformatf("v%0d_w1", i), 1, START + 32'd4, vecs[i].w1);
      chk($sformatf("v%0d_done", i), done, vecs[i].done_e);
      chk($sformatf("v%0d_frame_err", i), frame_err, vecs[i].ferr_e);
      chk($sformatf("v%0d_other_err", i), {overrun_err, bus_err}, 0);
      chk($sformatf("v%0d_htrans", i), bus.ahblm_htrans, 0);
    end
    do_reset();
    for (int j = 0; j < 8; j++) send_byte(vecs[0].bytes[8*j +: 8], 1'b1);
    for (int j = 0; j < 8; j++) send_byte(8'h5A + 8'(j), 1'b1);
    cyc(10);
    chk("postdone_nwrites", wq.size(), 2);
    chk("postdone_busy", busy_cnt, 0);
    chk("postdone_flags", {done, overrun_err}, 2'b10);
    do_reset();
    serial_in = 1'b0;
    cyc(2);
    serial_in = 1'b1;
    cyc(30);
    chk("glitch_flags", {done, frame_err, overrun_err, bus_err}, 0);
    chk("glitch_nwrites", wq.size(), 0);
    for (int j = 0; j < 4; j++) send_byte(8'(j + 1), 1'b1);
    cyc(10);
    chk("glitch_nwrites2", wq.size(), 1);
    chk_write("glitch_w0", 0, START, 32'h04030201);
    do_reset();
    bus.ahblm_hready = 1'b0;
    for (int j = 0; j < 4; j++) send_byte(8'hC0 + 8'(j), 1'b1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      found = bus.ahblm_htrans == 2'b10;
      if (!found) cyc(1);
    end
    chk("ws_nonseq_seen", found, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk($sformatf("ws_addr_hold%0d", k), {bus.ahblm_haddr, bus.ahblm_htrans, bus.ahblm_hwrite}, {START, 2'b10, 1'b1});
    end
    bus.ahblm_hready = 1'b1;
    cyc(1);
    bus.ahblm_hready = 1'b0;
    bus.ahblm_hresp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk($sformatf("ws_data_hold%0d", k), {bus.ahblm_hwdata, bus.ahblm_htrans}, {32'hC3C2C1C0, 2'b00});
    end
    bus.ahblm_hready = 1'b1;
    cyc(1);
    bus.ahblm_hresp = 1'b0;
    cyc(3);
    chk("ws_bus_err", bus_err, 1);
    chk("ws_addr_adv", bus.ahblm_haddr, START + 32'd4);
    chk("ws_nwrites", wq.size(), 1);
    chk_write("ws_w0", 0, START, 32'hC3C2C1C0);
    do_reset();
    bus.ahblm_hready = 1'b0;
    for (int j = 0; j < 8; j++) send_byte(8'(j + 1), 1'b1);
    cyc(5);
    chk("ovr_flag", overrun_err, 1);
    chk("ovr_stalled", {wq.size() == 0, bus.ahblm_htrans}, {1'b1, 2'b10});
    bus.ahblm_hready = 1'b1;
    cyc(10);
    chk("ovr_nwrites", wq.size(), 1);
    chk_write("ovr_w0", 0, START, 32'h04030201);
    chk("ovr_state", {done, overrun_err, bus.ahblm_haddr}, {1'b0, 1'b1, START + 32'd4});
    do_reset();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    for (int j = 0; j < 4; j++) send_byte(8'h11 * 8'(j + 1), 1'b1);
    cyc(10);
    chk("rstmid_nwrites", wq.size(), 1);
    chk_write("rstmid_w0", 0, START, 32'h44332211);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_mem_load.md
# serial_mem_load

Serial-to-memory loader: receives an 8N1 UART byte stream on one pin, packs bytes little-endian into 32-bit words, and writes them as an AHB-Lite master to consecutive word addresses from `ADDR_START` up to, but not including, `ADDR_STOP`. It is the inbound counterpart of the memory-dump master. It attaches to a crossbar master port in place of the CPU, so a host can fill boot SRAM over the wire on FPGA.

## Interface
- `ADDR_START`, 32'h20080000, first word address written (4-byte aligned)
- `ADDR_STOP`, 32'h20082000, exclusive end address (4-byte aligned, > `ADDR_START`)
- `CLK_DIV`, 16, clk cycles per serial bit (even, ≥ 8)
- `clk` in 1: sole clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `serial_in` in 1: UART RX line, idle high, asynchronous to `clk`
- `ahblm_hready` in 1: AHB-Lite transfer ready
- `ahblm_hresp` in 1: AHB-Lite error response
- `ahblm_haddr` out 32: address
- `ahblm_hwrite` out 1: write strobe
- `ahblm_htrans` out 2: transfer type, IDLE (2'b00) or NONSEQ (2'b10) only
- `ahblm_hsize` out 3: constant 3'b010
- `ahblm_hburst` out 3: constant 3'b000
- `ahblm_hprot` out 4: constant 4'b0011
- `ahblm_hmastlock` out 1: constant 0
- `ahblm_hwdata` out 32: write data
- `ahblm_hrdata` in 32: unused
- `done` out 1: last word written, sticky
- `frame_err` out 1: stop bit sampled low, sticky
- `overrun_err` out 1: word dropped because the write buffer was full, sticky
- `bus_err` out 1: `hresp` seen during a data phase, sticky

## Operation
- Input path: 2-flop synchroniser on `serial_in`, reset value 1. All RX logic uses the synchronised value.
- RX FSM states:
  - IDLE: move to START when the line is low.
  - START: count `CLK_DIV/2` cycles, then resample. If low, go to DATA. If high, treat as a glitch and return to IDLE; no error is flagged.
  - DATA: sample every `CLK_DIV` cycles, 8 samples, LSB first.
  - STOP: sample after a further `CLK_DIV` cycles. If high, the byte is valid. If low, set `frame_err` and discard the byte. Either way, return to IDLE.
- Packing: a 2-bit byte counter places byte n at bits [8n+7:8n]. On the 4th valid byte the word moves to the write buffer and the counter wraps to 0. A discarded byte does not advance the counter.
- Write buffer: one word plus a `pending` flag. If a word completes while `pending` is already 1, the new word is dropped and `overrun_err` is set.
- Bus FSM states:
  - B_IDLE: `htrans` = IDLE, `hwrite` = 0. Go to B_ADDR when `pending` is 1 and `done` is 0.
  - B_ADDR: `htrans` = NONSEQ, `hwrite` = 1, `haddr` = current address. Held stable until `hready` is sampled high, then go to B_DATA.
  - B_DATA: `htrans` = IDLE, `hwdata` = buffer word, held until `hready` is high. On that cycle: clear `pending`, add 4 to the address, set `bus_err` if `hresp` is 1, and return to B_IDLE.
- Termination: when the incremented address equals `ADDR_STOP`, set `done`. The bus stays IDLE from then on. RX keeps running, but completed words are discarded silently, with no overrun flagged.
- Simultaneous events: if a new word completes in the same cycle that B_DATA retires, the buffer accepts it with no overrun (clear takes priority before set).
- Reset values:
  - `haddr` = `ADDR_START`; `htrans` = 0; `hwrite` = 0; `hwdata` = 0.
  - All flags 0; byte counter 0; both FSMs idle.
  - Reset mid-transfer abandons the transfer and the partial word immediately.

## Timing
- Synchroniser latency: 2 cycles.
- Start edge to first data-bit sample: `CLK_DIV/2` + `CLK_DIV` cycles.
- Byte valid 1 cycle after the stop-bit sample.
- Buffer load to NONSEQ on the bus: 1 cycle. With zero-wait slaves a write occupies 2 bus cycles.
- Writes are never pipelined back-to-back; at least 1 IDLE cycle separates them.
- Bus throughput far exceeds serial rate, so overrun occurs only if the slave stalls for more than about 40·`CLK_DIV` cycles.

## Test plan
- Nominal load (`CLK_DIV`=8, `ADDR_STOP`=`ADDR_START`+8): send bytes 0x78 0x56 0x34 0x12 0xEF 0xBE 0xAD 0xDE → expect writes 0x12345678 @0x20080000 and 0xDEADBEEF @0x20080004; `done`=1; `htrans` stays 0 afterwards.
- Framing error: send 0xAA with stop bit 0, then 4 good bytes 01 02 03 04 → `frame_err`=1; one write of 0x04030201 @`ADDR_START`.
- Glitch: a 2-cycle low pulse on `serial_in` → no byte accepted, no flags set, counter unchanged.
- Wait states and error: slave holds `hready`=0 for 5 cycles in the address phase and in the data phase, with `hresp`=1 → `haddr`/`hwdata` stable throughout; `bus_err`=1; address advances by 4.
- Overrun: hold `hready` low across 8 received bytes → first word is written once `hready` rises; second word is dropped; `overrun_err`=1.
- Reset mid-word: assert `rst` after 2 bytes, then send 4 bytes → a single write of those 4 bytes @`ADDR_START`.
